// File: rtl/demux_destinos_pkg.sv
// Shared word format and routing encodings for the destination demux.
package demux_destinos_pkg;

  localparam int unsigned DATA_W    = 6;
  localparam int unsigned DEST_BIT  = 4;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  typedef logic [DATA_W-1:0] word_t;

  function automatic logic dest_of(input word_t w);
    return w[DEST_BIT];
  endfunction

endpackage

// File: rtl/demux_destinos_if.sv
// Upstream pop/data, downstream FIFO strobes and status of the destination demux.
interface demux_destinos_if #(
  parameter int unsigned CNT_W = 8
);
  import demux_destinos_pkg::*;

  logic             pop_delay_VC0;
  logic             pop_delay_VC1;
  word_t            data_in;
  logic             full_fifo_D0;
  logic             full_fifo_D1;
  logic             push_D0;
  logic             push_D1;
  word_t            data_D0;
  word_t            data_D1;
  logic             stall;
  logic             overflow_err;
  logic [CNT_W-1:0] cnt_D0;
  logic [CNT_W-1:0] cnt_D1;

  modport slave (
    input  pop_delay_VC0, pop_delay_VC1, data_in, full_fifo_D0, full_fifo_D1,
    output push_D0, push_D1, data_D0, data_D1, stall, overflow_err, cnt_D0, cnt_D1
  );

  modport master (
    output pop_delay_VC0, pop_delay_VC1, data_in, full_fifo_D0, full_fifo_D1,
    input  push_D0, push_D1, data_D0, data_D1, stall, overflow_err, cnt_D0, cnt_D1
  );

endinterface

// File: rtl/demux_destinos_buffer_2_entradas.sv
// Two-entry in-order buffer: output register plus a younger skid register, sticky drop flag.
module buffer_2_entradas
  import demux_destinos_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid_i,
  input  word_t in_data_i,
  input  logic  drain_i,
  output logic  out_valid_o,
  output word_t out_data_o,
  output logic  skid_valid_o,
  output logic  drop_o
);

  logic  out_v_q, out_v_d;
  logic  skid_v_q, skid_v_d;
  word_t out_q, out_d;
  word_t skid_q, skid_d;
  logic  drop_q, drop_d;
  logic  out_free;

  assign out_free = ~out_v_q | drain_i;

  always_comb begin
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    out_d    = out_q;
    skid_d   = skid_q;
    drop_d   = drop_q;
    if (out_free) begin
      if (skid_v_q) begin
        // Skid is older than any arriving word, so it moves up first.
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = in_valid_i;
        if (in_valid_i) skid_d = in_data_i;
      end else begin
        out_v_d = in_valid_i;
        if (in_valid_i) out_d = in_data_i;
      end
    end else if (in_valid_i) begin
      if (!skid_v_q) begin
        skid_v_d = 1'b1;
        skid_d   = in_data_i;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid_o  = out_v_q;
  assign out_data_o   = out_q;
  assign skid_valid_o = skid_v_q;
  assign drop_o       = drop_q;

endmodule

// File: rtl/demux_destinos.sv
// Routes arbitrated words to destination FIFO D0 or D1 through a 2-entry buffer,
// counting pushes per destination.
module demux_destinos
  import demux_destinos_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  demux_destinos_if.slave   bus
);

  logic             valid_in;
  logic             out_v;
  word_t            out_data;
  logic             skid_v;
  logic             drop;
  logic             out_dest;
  logic             drain_c;
  logic             push_d0_c;
  logic             push_d1_c;
  logic [CNT_W-1:0] cnt_d0_q;
  logic [CNT_W-1:0] cnt_d1_q;

  // Simultaneous pops are illegal upstream; they collapse into one word.
  assign valid_in = bus.pop_delay_VC0 | bus.pop_delay_VC1;

  buffer_2_entradas u_buf (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (valid_in),
    .in_data_i    (bus.data_in),
    .drain_i      (drain_c),
    .out_valid_o  (out_v),
    .out_data_o   (out_data),
    .skid_valid_o (skid_v),
    .drop_o       (drop)
  );

  // Head-of-line only: the head word's own destination decides whether anything moves.
  assign out_dest  = dest_of(out_data);
  assign drain_c   = out_v & ~((out_dest == DEST_D1) ? bus.full_fifo_D1 : bus.full_fifo_D0);
  assign push_d0_c = drain_c & (out_dest == DEST_D0);
  assign push_d1_c = drain_c & (out_dest == DEST_D1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else begin
      if (push_d0_c) cnt_d0_q <= cnt_d0_q + CNT_W'(1);
      if (push_d1_c) cnt_d1_q <= cnt_d1_q + CNT_W'(1);
    end
  end

  assign bus.push_D0      = push_d0_c;
  assign bus.push_D1      = push_d1_c;
  assign bus.data_D0      = out_data;
  assign bus.data_D1      = out_data;
  assign bus.stall        = skid_v | (out_v & ~drain_c);
  assign bus.overflow_err = drop;
  assign bus.cnt_D0       = cnt_d0_q;
  assign bus.cnt_D1       = cnt_d1_q;

endmodule

// File: tb/tb_demux_destinos.sv
// Self-checking bench for demux_destinos: directed table, reset, random vs queue model, counter wrap.
module tb_demux_destinos;
  import demux_destinos_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  demux_destinos_if #(.CNT_W(8)) ifa ();
  demux_destinos_if #(.CNT_W(2)) ifb ();

  demux_destinos #(.CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  demux_destinos #(.CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    logic  v0, v1;
    word_t d;
    logic  f0, f1;
    logic  chk;
    logic  p0, p1;
    word_t pd;
    logic  st, ovf;
  } vec_t;

  // Reference model: an ordered list of at most two waiting words.
  word_t mq[$];
  bit    m_ovf;
  int    m_c0, m_c1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_c0  = 0;
    m_c1  = 0;
  endtask

  task automatic step(input vec_t v);
    bit    mp0, mp1, mst, blocked, hd;
    word_t head;
    ifa.pop_delay_VC0 = v.v0;
    ifa.pop_delay_VC1 = v.v1;
    ifa.data_in       = v.d;
    ifa.full_fifo_D0  = v.f0;
    ifa.full_fifo_D1  = v.f1;
    @(negedge clk);
    head    = (mq.size() > 0) ? mq[0] : '0;
    hd      = head[DEST_BIT];
    blocked = hd ? v.f1 : v.f0;
    mp0     = (mq.size() > 0) && !blocked && !hd;
    mp1     = (mq.size() > 0) && !blocked && hd;
    mst     = (mq.size() == 2) || ((mq.size() == 1) && blocked);
    check("push_D0", 32'(ifa.push_D0), 32'(mp0));
    check("push_D1", 32'(ifa.push_D1), 32'(mp1));
    check("stall", 32'(ifa.stall), 32'(mst));
    check("overflow_err", 32'(ifa.overflow_err), 32'(m_ovf));
    check("cnt_D0", 32'(ifa.cnt_D0), 32'(m_c0 % 256));
    check("cnt_D1", 32'(ifa.cnt_D1), 32'(m_c1 % 256));
    if (mp0) check("data_D0", 32'(ifa.data_D0), 32'(head));
    if (mp1) check("data_D1", 32'(ifa.data_D1), 32'(head));
    if (v.chk) begin
      check("tbl_push_D0", 32'(ifa.push_D0), 32'(v.p0));
      check("tbl_push_D1", 32'(ifa.push_D1), 32'(v.p1));
      check("tbl_stall", 32'(ifa.stall), 32'(v.st));
      check("tbl_ovf", 32'(ifa.overflow_err), 32'(v.ovf));
      if (v.p0) check("tbl_data_D0", 32'(ifa.data_D0), 32'(v.pd));
      if (v.p1) check("tbl_data_D1", 32'(ifa.data_D1), 32'(v.pd));
    end
    @(posedge clk);
    if (mp0 || mp1) begin
      void'(mq.pop_front());
      if (mp0) m_c0++;
      else     m_c1++;
    end
    if (v.v0 || v.v1) begin
      if (mq.size() < 2) mq.push_back(v.d);
      else               m_ovf = 1'b1;
    end
    #1;
  endtask

  function automatic vec_t mk(input logic v0, input word_t d, input logic f0, input logic f1,
                              input logic p0, input logic p1, input word_t pd,
                              input logic st, input logic ovf);
    vec_t r;
    r.v0 = v0; r.v1 = 1'b0; r.d = d; r.f0 = f0; r.f1 = f1; r.chk = 1'b1;
    r.p0 = p0; r.p1 = p1; r.pd = pd; r.st = st; r.ovf = ovf;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t       rv;
    logic [1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset = 1'b1;
    ifa.pop_delay_VC0 = 0; ifa.pop_delay_VC1 = 0; ifa.data_in = '0;
    ifa.full_fifo_D0 = 0; ifa.full_fifo_D1 = 0;
    ifb.pop_delay_VC0 = 0; ifb.pop_delay_VC1 = 0; ifb.data_in = '0;
    ifb.full_fifo_D0 = 0; ifb.full_fifo_D1 = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_push_D0", 32'(ifa.push_D0), 32'd0);
    check("rst_stall", 32'(ifa.stall), 32'd0);
    check("rst_cnt_D0", 32'(ifa.cnt_D0), 32'd0);
    reset = 1'b0;

    //          v0  data   f0 f1  p0 p1 pdata  st ovf
    tbl.push_back(mk(1, 6'h05, 0, 0, 0, 0, 6'h00, 0, 0));  // single word to D0
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h05, 0, 0));
    tbl.push_back(mk(1, 6'h10, 0, 0, 0, 0, 6'h00, 0, 0));  // D1 then D0 back to back
    tbl.push_back(mk(1, 6'h03, 0, 0, 0, 1, 6'h10, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h03, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 6'h00, 0, 0));
    tbl.push_back(mk(1, 6'h01, 1, 0, 0, 0, 6'h00, 0, 0));  // backpressure, two held
    tbl.push_back(mk(1, 6'h02, 1, 0, 0, 0, 6'h00, 1, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h01, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h02, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 6'h00, 0, 0));
    tbl.push_back(mk(1, 6'h01, 1, 0, 0, 0, 6'h00, 0, 0));  // third word dropped
    tbl.push_back(mk(1, 6'h02, 1, 0, 0, 0, 6'h00, 1, 0));
    tbl.push_back(mk(1, 6'h03, 1, 0, 0, 0, 6'h00, 1, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h01, 1, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h02, 0, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 6'h00, 0, 1));
    tbl.push_back(mk(1, 6'h01, 1, 0, 0, 0, 6'h00, 0, 1));  // D1 word stuck behind blocked D0
    tbl.push_back(mk(1, 6'h10, 1, 0, 0, 0, 6'h00, 1, 1));
    tbl.push_back(mk(0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 1, 0, 6'h01, 1, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 1, 6'h10, 0, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 6'h00, 0, 1));
    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset with both buffer entries occupied
    step(mk(1, 6'h01, 1, 0, 0, 0, 6'h00, 0, 1));
    step(mk(1, 6'h02, 1, 0, 0, 0, 6'h00, 1, 1));
    ifa.pop_delay_VC0 = 0;
    #1;
    reset = 1'b1;
    #1;
    check("arst_push_D0", 32'(ifa.push_D0), 32'd0);
    check("arst_push_D1", 32'(ifa.push_D1), 32'd0);
    check("arst_stall", 32'(ifa.stall), 32'd0);
    check("arst_ovf", 32'(ifa.overflow_err), 32'd0);
    check("arst_cnt_D0", 32'(ifa.cnt_D0), 32'd0);
    check("arst_cnt_D1", 32'(ifa.cnt_D1), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      rv.chk = 1'b0;
      rv.p0 = 0; rv.p1 = 0; rv.pd = '0; rv.st = 0; rv.ovf = 0;
      rv.v0 = ($urandom_range(0, 99) < 55);
      rv.v1 = ($urandom_range(0, 99) < 20);
      rv.d  = 6'($urandom);
      rv.f0 = ($urandom_range(0, 99) < 35);
      rv.f1 = ($urandom_range(0, 99) < 35);
      step(rv);
    end

    // Counter wrap on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      ifb.pop_delay_VC1 = 1'b1;
      ifb.data_in       = 6'h10;
      @(posedge clk);
      #1;
      ifb.pop_delay_VC1 = 1'b0;
      @(posedge clk);
      #1;
      check("wrap_cnt_D1", 32'(ifb.cnt_D1), 32'(wrap_exp[i]));
    end
    check("wrap_cnt_D0", 32'(ifb.cnt_D0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
